// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with a registered match pulse
// and a saturating match counter; pattern, length and overlap mode are shadowed on cfg_load.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h0C,
  parameter logic [LEN_W-1:0]   DEF_LEN     = 4'd4,
  parameter logic               DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam int                FILL_W   = $clog2(MAX_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  // The oldest history bit would fall off before it could ever be compared,
  // so only MAX_LEN-1 previous bits are kept; x supplies the newest one.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               cfg_err_q, cfg_err_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;

  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               hit;

  always_comb begin
    nh   = {hist_q, x};
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    fill_ok = (int'(fill_q) + 1) >= int'(len_q);
    hit     = en & ~cfg_err_q & fill_ok & ((nh & mask) == (pattern_q & mask));

    hist_d    = hist_q;
    fill_d    = fill_q;
    z_d       = 1'b0;
    count_d   = count_q;
    cfg_err_d = cfg_err_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      count_d   = '0;
      cfg_err_d = (int'(cfg_len) < 2) || (int'(cfg_len) > MAX_LEN);
    end else if (en) begin
      hist_d = nh[MAX_LEN-2:0];
      z_d    = hit;
      // Non-overlapping mode restarts the fill count so matched bits are not reused.
      if (hit && !overlap_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if (hit && (count_q != '1)) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      z_q       <= 1'b0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
      pattern_q <= DEF_PATTERN;
      len_q     <= DEF_LEN;
      overlap_q <= DEF_OVERLAP;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      z_q       <= z_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
    end
  end

  assign z           = z_q;
  assign match_count = count_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector tables, hand-written corner cases
// and a randomized run, all compared against a queue-based reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       x;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       z, z2;
  logic       cfg_err, cfg_err2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  // Reference model: bits received since the last clear, oldest at the front.
  bit         mq[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_err, m_z;
  int         m_cnt, m_cnt2;

  typedef struct {
    logic en;
    logic x;
    logic exp_z;
  } vec_t;
  vec_t vecs[$];

  seq_detector_param dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z), .match_count(match_count), .cfg_err(cfg_err)
  );

  seq_detector_param #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z2), .match_count(match_count2), .cfg_err(cfg_err2)
  );

  always #5 clk = ~clk;

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, " z"}, 32'(z), 32'(m_z));
    checkOne({tag, " count"}, 32'(match_count), m_cnt);
    checkOne({tag, " cfg_err"}, 32'(cfg_err), 32'(m_err));
    checkOne({tag, " z_small"}, 32'(z2), 32'(m_z));
    checkOne({tag, " count_small"}, 32'(match_count2), m_cnt2);
  endtask

  task automatic modelReset();
    mq.delete();
    m_pat  = 8'h0C;
    m_len  = 4;
    m_ovl  = 1'b0;
    m_err  = 1'b0;
    m_z    = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  task automatic modelEdge(input logic e, input logic xx, input logic ld);
    bit hit;
    bit b;
    if (ld) begin
      m_pat  = cfg_pattern;
      m_len  = int'(cfg_len);
      m_ovl  = cfg_overlap;
      m_err  = (m_len < 2) || (m_len > 8);
      mq.delete();
      m_z    = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
    end else if (!e) begin
      m_z = 1'b0;
    end else begin
      hit = 1'b0;
      if (!m_err && (mq.size() + 1 >= m_len)) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          b = (i == 0) ? bit'(xx) : mq[mq.size() - i];
          if (b != m_pat[i]) hit = 1'b0;
        end
      end
      m_z = hit;
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (hit && !m_ovl) begin
        mq.delete();
      end else begin
        mq.push_back(bit'(xx));
        if (mq.size() > 8) void'(mq.pop_front());
      end
    end
  endtask

  task automatic applyStimulus(input logic e, input logic xx, input logic ld, input string tag);
    en       = e;
    x        = xx;
    cfg_load = ld;
    modelEdge(e, xx, ld);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic doLoad(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input string tag);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    applyStimulus(1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic pushVec(input logic e, input logic xx, input logic ez);
    vec_t v;
    v.en = e; v.x = xx; v.exp_z = ez;
    vecs.push_back(v);
  endtask

  task automatic runVecs(input string tag);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].x, 1'b0, tag);
      checkOne($sformatf("%s tbl_z[%0d]", tag, i), 32'(z), 32'(vecs[i].exp_z));
    end
    vecs.delete();
  endtask

  // Called just after a check (#1 past an edge); reset is asserted and released between edges.
  task automatic midReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    x           = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    modelReset();
    #12;
    checkOutput("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: default 1100 pattern, non-overlapping
    pushVec(1,1,0); pushVec(1,1,0); pushVec(1,0,0); pushVec(1,0,1);
    pushVec(1,1,0); pushVec(1,1,0); pushVec(1,0,0); pushVec(1,0,1);
    runVecs("T1");
    checkOne("T1 final count", 32'(match_count), 2);

    // T2: 1010 overlapping
    doLoad(8'h0A, 4'd4, 1'b1, "T2 load");
    pushVec(1,1,0); pushVec(1,0,0); pushVec(1,1,0);
    pushVec(1,0,1); pushVec(1,1,0); pushVec(1,0,1);
    runVecs("T2");
    checkOne("T2 final count", 32'(match_count), 2);

    // T2b: same stream, non-overlapping
    doLoad(8'h0A, 4'd4, 1'b0, "T2b load");
    pushVec(1,1,0); pushVec(1,0,0); pushVec(1,1,0);
    pushVec(1,0,1); pushVec(1,1,0); pushVec(1,0,0);
    runVecs("T2b");
    checkOne("T2b final count", 32'(match_count), 1);

    // T3: enable gap inside a 1100 match
    doLoad(8'h0C, 4'd4, 1'b0, "T3 load");
    pushVec(1,1,0); pushVec(1,1,0);
    for (int i = 0; i < 5; i++) pushVec(0, logic'(i[0]), 0);
    pushVec(1,0,0); pushVec(1,0,1);
    runVecs("T3");
    checkOne("T3 final count", 32'(match_count), 1);

    // T4: 11 overlapping, seven ones; the 2-bit counter saturates
    doLoad(8'h03, 4'd2, 1'b1, "T4 load");
    pushVec(1,1,0);
    for (int i = 0; i < 6; i++) pushVec(1,1,1);
    runVecs("T4");
    checkOne("T4 count", 32'(match_count), 6);
    checkOne("T4 count_small", 32'(match_count2), 3);

    // T5: reset mid-pattern, then an invalid length
    doLoad(8'h0C, 4'd4, 1'b0, "T5 load");
    applyStimulus(1,1,0,"T5");
    applyStimulus(1,1,0,"T5");
    applyStimulus(1,0,0,"T5");
    midReset("T5 reset");
    applyStimulus(1,0,0,"T5 after");
    checkOne("T5 no z", 32'(z), 0);
    doLoad(8'h0C, 4'd0, 1'b0, "T5 badlen");
    checkOne("T5 cfg_err", 32'(cfg_err), 1);
    pushVec(1,1,0); pushVec(1,1,0); pushVec(1,0,0); pushVec(1,0,0);
    runVecs("T5 err");
    // A live pulse must drop as soon as reset asserts.
    doLoad(8'h0C, 4'd4, 1'b0, "T5 reload");
    checkOne("T5 err cleared", 32'(cfg_err), 0);
    pushVec(1,1,0); pushVec(1,1,0); pushVec(1,0,0); pushVec(1,0,1);
    runVecs("T5 pulse");
    midReset("T5 async drop");
    checkOne("T5 async z", 32'(z), 0);

    // T6: cfg_load beats en on the completing edge
    doLoad(8'h0C, 4'd4, 1'b0, "T6 load");
    applyStimulus(1,1,0,"T6");
    applyStimulus(1,1,0,"T6");
    applyStimulus(1,0,0,"T6");
    applyStimulus(1,0,1,"T6 collide");
    checkOne("T6 z", 32'(z), 0);
    checkOne("T6 count", 32'(match_count), 0);

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(2, 4));
        cfg_overlap = 1'($urandom);
        applyStimulus(1'($urandom), 1'($urandom), 1'b1, "rand load");
      end else begin
        applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
